// File: rtl/morse_scheduler_pkg.sv
// Purpose: shared Morse scheduler types: FSM states, unit multiples, ASCII constants, code-table entry.
// Latency: n/a (declarations and a pure combinational helper only).
// Backpressure: n/a.
package morse_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOOKUP,
    ST_MARK,
    ST_ELEM_GAP,
    ST_CHAR_GAP,
    ST_WORD_GAP
  } state_t;

  // Durations in Morse time units
  localparam int UNITS_DOT      = 1;
  localparam int UNITS_DASH     = 3;
  localparam int UNITS_ELEM_GAP = 1;
  localparam int UNITS_CHAR_GAP = 3;
  localparam int UNITS_WORD_GAP = 4;

  localparam logic [6:0] ASCII_SPACE   = 7'h20;
  localparam logic [6:0] ASCII_LOWER_A = 7'h61;
  localparam logic [6:0] ASCII_LOWER_Z = 7'h7A;
  localparam logic [6:0] ASCII_CASE    = 7'h20;

  // pattern[0] is the first element sent; a 1 bit is a dash
  typedef struct packed {
    logic       valid;
    logic [2:0] len;
    logic [4:0] pattern;
  } morse_code_t;

  // Build a table entry from the code written in reading order: the first
  // element sits in bit len-1 of seq, so ".-" is written 5'b01.
  function automatic morse_code_t mk_code(input logic [2:0] len, input logic [4:0] seq);
    logic [4:0]  rev;
    morse_code_t c;
    rev       = {seq[0], seq[1], seq[2], seq[3], seq[4]};
    c.valid   = 1'b1;
    c.len     = len;
    c.pattern = rev >> (3'd5 - len);
    return c;
  endfunction

endpackage

// File: rtl/morse_lut.sv
// Purpose: ASCII (7-bit) to Morse code ROM; letters are case folded, digits supported, rest invalid.
// Latency: purely combinational.
// Backpressure: none; the output follows the input.
module morse_lut
  import morse_scheduler_pkg::*;
(
  input  logic [6:0]  ascii_i,
  output morse_code_t code_o
);

  logic [6:0] folded;

  // Fold lower-case letters onto upper case, then look up the code
  always_comb begin
    folded = ascii_i;
    if (ascii_i >= ASCII_LOWER_A && ascii_i <= ASCII_LOWER_Z) begin
      folded = ascii_i - ASCII_CASE;
    end
    code_o = '0;
    case (folded)
      7'h41: code_o = mk_code(3'd2, 5'b01);     // A .-
      7'h42: code_o = mk_code(3'd4, 5'b1000);   // B -...
      7'h43: code_o = mk_code(3'd4, 5'b1010);   // C -.-.
      7'h44: code_o = mk_code(3'd3, 5'b100);    // D -..
      7'h45: code_o = mk_code(3'd1, 5'b0);      // E .
      7'h46: code_o = mk_code(3'd4, 5'b0010);   // F ..-.
      7'h47: code_o = mk_code(3'd3, 5'b110);    // G --.
      7'h48: code_o = mk_code(3'd4, 5'b0000);   // H ....
      7'h49: code_o = mk_code(3'd2, 5'b00);     // I ..
      7'h4A: code_o = mk_code(3'd4, 5'b0111);   // J .---
      7'h4B: code_o = mk_code(3'd3, 5'b101);    // K -.-
      7'h4C: code_o = mk_code(3'd4, 5'b0100);   // L .-..
      7'h4D: code_o = mk_code(3'd2, 5'b11);     // M --
      7'h4E: code_o = mk_code(3'd2, 5'b10);     // N -.
      7'h4F: code_o = mk_code(3'd3, 5'b111);    // O ---
      7'h50: code_o = mk_code(3'd4, 5'b0110);   // P .--.
      7'h51: code_o = mk_code(3'd4, 5'b1101);   // Q --.-
      7'h52: code_o = mk_code(3'd3, 5'b010);    // R .-.
      7'h53: code_o = mk_code(3'd3, 5'b000);    // S ...
      7'h54: code_o = mk_code(3'd1, 5'b1);      // T -
      7'h55: code_o = mk_code(3'd3, 5'b001);    // U ..-
      7'h56: code_o = mk_code(3'd4, 5'b0001);   // V ...-
      7'h57: code_o = mk_code(3'd3, 5'b011);    // W .--
      7'h58: code_o = mk_code(3'd4, 5'b1001);   // X -..-
      7'h59: code_o = mk_code(3'd4, 5'b1011);   // Y -.--
      7'h5A: code_o = mk_code(3'd4, 5'b1100);   // Z --..
      7'h30: code_o = mk_code(3'd5, 5'b11111);  // 0 -----
      7'h31: code_o = mk_code(3'd5, 5'b01111);  // 1 .----
      7'h32: code_o = mk_code(3'd5, 5'b00111);  // 2 ..---
      7'h33: code_o = mk_code(3'd5, 5'b00011);  // 3 ...--
      7'h34: code_o = mk_code(3'd5, 5'b00001);  // 4 ....-
      7'h35: code_o = mk_code(3'd5, 5'b00000);  // 5 .....
      7'h36: code_o = mk_code(3'd5, 5'b10000);  // 6 -....
      7'h37: code_o = mk_code(3'd5, 5'b11000);  // 7 --...
      7'h38: code_o = mk_code(3'd5, 5'b11100);  // 8 ---..
      7'h39: code_o = mk_code(3'd5, 5'b11110);  // 9 ----.
      default: code_o = '0;
    endcase
  end

endmodule

// File: rtl/morse_scheduler.sv
// Purpose: pops ASCII bytes from the character FIFO and keys them out as Morse dots/dashes/gaps.
// Latency: pop strobe in cycle N, key_o first high in N+2; every timed state lasts k*UNIT_TICKS cycles.
// Backpressure: fetches only when enabled in IDLE and the FIFO is non-empty; one pop per character.
module morse_scheduler
  import morse_scheduler_pkg::*;
#(
  parameter int UNIT_TICKS = 12_000_000,
  parameter int WORD_BITS  = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic                 fifo_empty_i,
  input  logic [WORD_BITS-1:0] fifo_rdata_i,
  output logic                 fifo_read_o,
  output logic                 key_o,
  output logic                 busy_o,
  output logic                 char_done_o,
  output logic                 bad_char_o
);

  localparam int TW = $clog2(4 * UNIT_TICKS);

  localparam logic [TW-1:0] T_DOT      = TW'(UNITS_DOT * UNIT_TICKS - 1);
  localparam logic [TW-1:0] T_DASH     = TW'(UNITS_DASH * UNIT_TICKS - 1);
  localparam logic [TW-1:0] T_ELEM_GAP = TW'(UNITS_ELEM_GAP * UNIT_TICKS - 1);
  localparam logic [TW-1:0] T_CHAR_GAP = TW'(UNITS_CHAR_GAP * UNIT_TICKS - 1);
  localparam logic [TW-1:0] T_WORD_GAP = TW'(UNITS_WORD_GAP * UNIT_TICKS - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [6:0]    char_q, char_d;
  logic [2:0]    len_q, len_d;
  logic [4:0]    pat_q, pat_d;
  logic [2:0]    idx_q, idx_d;
  logic          fifo_read_q, fifo_read_d;
  logic          key_q, key_d;
  logic          busy_q, busy_d;
  logic          char_done_q, char_done_d;
  logic          bad_char_q, bad_char_d;

  morse_code_t   lut_code;
  logic [2:0]    nxt_idx;

  // Bits above the 7-bit ASCII range are deliberately ignored
  if (WORD_BITS > 7) begin : g_hi_bits
    logic unused_hi_bits;
    assign unused_hi_bits = ^fifo_rdata_i[WORD_BITS-1:7];
  end

  morse_lut u_lut (
    .ascii_i (char_q),
    .code_o  (lut_code)
  );

  assign nxt_idx = idx_q + 3'd1;

  // Next-state, timer and element sequencing; outputs derived from the next state
  always_comb begin
    state_d     = state_q;
    timer_d     = (timer_q != '0) ? timer_q - 1'b1 : timer_q;
    char_d      = char_q;
    len_d       = len_q;
    pat_d       = pat_q;
    idx_d       = idx_q;
    char_done_d = 1'b0;
    bad_char_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable_i && !fifo_empty_i) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        char_d  = fifo_rdata_i[6:0];
        state_d = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (char_q == ASCII_SPACE) begin
          state_d = ST_WORD_GAP;
          timer_d = T_WORD_GAP;
        end else if (lut_code.valid) begin
          len_d   = lut_code.len;
          pat_d   = lut_code.pattern;
          idx_d   = 3'd0;
          state_d = ST_MARK;
          timer_d = lut_code.pattern[0] ? T_DASH : T_DOT;
        end else begin
          bad_char_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_MARK: begin
        if (timer_q == '0) begin
          if (idx_q == len_q - 3'd1) begin
            state_d = ST_CHAR_GAP;
            timer_d = T_CHAR_GAP;
          end else begin
            state_d = ST_ELEM_GAP;
            timer_d = T_ELEM_GAP;
          end
        end
      end
      ST_ELEM_GAP: begin
        if (timer_q == '0) begin
          idx_d   = nxt_idx;
          state_d = ST_MARK;
          timer_d = pat_q[nxt_idx] ? T_DASH : T_DOT;
        end
      end
      ST_CHAR_GAP, ST_WORD_GAP: begin
        if (timer_q == '0) begin
          char_done_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    fifo_read_d = (state_d == ST_FETCH);
    key_d       = (state_d == ST_MARK);
    busy_d      = (state_d != ST_IDLE);
  end

  // State, datapath and registered outputs; reset silences the key at once
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      char_q      <= '0;
      len_q       <= '0;
      pat_q       <= '0;
      idx_q       <= '0;
      fifo_read_q <= 1'b0;
      key_q       <= 1'b0;
      busy_q      <= 1'b0;
      char_done_q <= 1'b0;
      bad_char_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      char_q      <= char_d;
      len_q       <= len_d;
      pat_q       <= pat_d;
      idx_q       <= idx_d;
      fifo_read_q <= fifo_read_d;
      key_q       <= key_d;
      busy_q      <= busy_d;
      char_done_q <= char_done_d;
      bad_char_q  <= bad_char_d;
    end
  end

  assign fifo_read_o = fifo_read_q;
  assign key_o       = key_q;
  assign busy_o      = busy_q;
  assign char_done_o = char_done_q;
  assign bad_char_o  = bad_char_q;

endmodule

// File: tb/tb_morse_scheduler.sv
// Purpose: directed bench for morse_scheduler with a small FIFO model and cycle-traced key waveform.
// Latency: expected waveforms are written relative to each observed pop strobe.
// Backpressure: the FIFO model pops on the strobe and updates its empty flag one edge later.
module tb_morse_scheduler;

  localparam int U     = 4;
  localparam int DEPTH = 128;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       enable_i = 1'b0;
  logic       fifo_empty_i = 1'b1;
  logic [7:0] fifo_rdata_i = 8'h00;
  logic       fifo_read_o, key_o, busy_o, char_done_o, bad_char_o;

  int n_checks = 0;
  int n_fail   = 0;

  morse_scheduler #(.UNIT_TICKS(U), .WORD_BITS(8)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .enable_i     (enable_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rdata_i (fifo_rdata_i),
    .fifo_read_o  (fifo_read_o),
    .key_o        (key_o),
    .busy_o       (busy_o),
    .char_done_o  (char_done_o),
    .bad_char_o   (bad_char_o)
  );

  always #5 clk_i = ~clk_i;

  // FIFO model
  logic [7:0] fifo_q[$];

  task automatic fifo_refresh();
    fifo_empty_i = (fifo_q.size() == 0);
    fifo_rdata_i = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_refresh();
  endtask

  initial begin
    logic       rd_seen;
    logic [7:0] dropped;
    forever begin
      @(negedge clk_i);
      rd_seen = fifo_read_o;
      @(posedge clk_i);
      #1;
      if (rd_seen && fifo_q.size() > 0) dropped = fifo_q.pop_front();
      fifo_refresh();
    end
  end

  // Cycle trace, sampled on the falling edge
  logic key_tr [0:DEPTH-1];
  logic busy_tr[0:DEPTH-1];
  logic rd_tr  [0:DEPTH-1];
  logic done_tr[0:DEPTH-1];
  logic bad_tr [0:DEPTH-1];
  int   cnt_rd, cnt_done, cnt_bad, cnt_key;

  task automatic capture(input int n);
    cnt_rd = 0; cnt_done = 0; cnt_bad = 0; cnt_key = 0;
    for (int i = 0; i < DEPTH; i++) begin
      key_tr[i] = 1'bx; busy_tr[i] = 1'bx; rd_tr[i] = 1'bx; done_tr[i] = 1'bx; bad_tr[i] = 1'bx;
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      key_tr[i]  = key_o;
      busy_tr[i] = busy_o;
      rd_tr[i]   = fifo_read_o;
      done_tr[i] = char_done_o;
      bad_tr[i]  = bad_char_o;
      if (fifo_read_o === 1'b1) cnt_rd++;
      if (char_done_o === 1'b1) cnt_done++;
      if (bad_char_o === 1'b1) cnt_bad++;
      if (key_o === 1'b1) cnt_key++;
    end
  endtask

  function automatic int first_read();
    for (int i = 0; i < DEPTH; i++) if (rd_tr[i] === 1'b1) return i;
    return -1;
  endfunction

  task automatic wait_read(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk_i);
      if (fifo_read_o === 1'b1) ok = 1'b1;
    end
  endtask

  // Expected key waveform builder
  logic exp_key[0:DEPTH-1];
  int   exp_len;

  task automatic exp_clear();
    exp_len = 0;
  endtask

  task automatic seg(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      exp_key[exp_len] = lvl;
      exp_len++;
    end
  endtask

  function automatic int key_mismatches(input int start);
    int n = 0;
    for (int j = 0; j < exp_len; j++) begin
      if (start + j < 0 || start + j >= DEPTH) n++;
      else if (key_tr[start+j] !== exp_key[j]) n++;
    end
    return n;
  endfunction

  task automatic test_reset();
    #12;
    n_checks++; if (key_o !== 1'b0)       begin n_fail++; $display("FAIL reset_key: got %b want 0", key_o); end
    n_checks++; if (busy_o !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_checks++; if (fifo_read_o !== 1'b0) begin n_fail++; $display("FAIL reset_read: got %b want 0", fifo_read_o); end
    n_checks++; if (char_done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", char_done_o); end
    n_checks++; if (bad_char_o !== 1'b0)  begin n_fail++; $display("FAIL reset_bad: got %b want 0", bad_char_o); end
    @(negedge clk_i);
    reset_i  = 1'b0;
    enable_i = 1'b1;
    capture(6);
    n_checks++; if (cnt_rd != 0)         begin n_fail++; $display("FAIL empty_no_read: got %0d reads want 0", cnt_rd); end
    n_checks++; if (busy_tr[5] !== 1'b0) begin n_fail++; $display("FAIL empty_idle_busy: got %b want 0", busy_tr[5]); end
  endtask

  task automatic test_letter_e();
    int r, nm;
    push(8'h45);
    capture(40);
    r = first_read();
    n_checks++; if (r < 0) begin n_fail++; $display("FAIL e_read_seen: got none want one"); r = 0; end
    n_checks++; if (cnt_rd != 1) begin n_fail++; $display("FAIL e_read_count: got %0d want 1", cnt_rd); end
    exp_clear(); seg(0, 1); seg(1, 4); seg(0, 12);
    nm = key_mismatches(r + 1);
    n_checks++; if (nm != 0) begin n_fail++; $display("FAIL e_key_wave: %0d cycles differ want 0", nm); end
    n_checks++; if (busy_tr[r+17] !== 1'b1) begin n_fail++; $display("FAIL e_busy_gap: got %b want 1", busy_tr[r+17]); end
    n_checks++; if (done_tr[r+18] !== 1'b1) begin n_fail++; $display("FAIL e_done_pos: got %b want 1", done_tr[r+18]); end
    n_checks++; if (busy_tr[r+18] !== 1'b0) begin n_fail++; $display("FAIL e_busy_end: got %b want 0", busy_tr[r+18]); end
    n_checks++; if (cnt_done != 1) begin n_fail++; $display("FAIL e_done_count: got %0d want 1", cnt_done); end
  endtask

  task automatic test_letter_a();
    logic [7:0] chars[2];
    int r, nm;
    chars[0] = 8'h41; chars[1] = 8'h61;
    for (int c = 0; c < 2; c++) begin
      push(chars[c]);
      capture(50);
      r = first_read();
      if (r < 0) r = 0;
      exp_clear(); seg(0, 1); seg(1, 4); seg(0, 4); seg(1, 12); seg(0, 12);
      nm = key_mismatches(r + 1);
      n_checks++; if (nm != 0) begin n_fail++; $display("FAIL a_key_wave(%h): %0d cycles differ want 0", chars[c], nm); end
      n_checks++; if (done_tr[r+34] !== 1'b1 || cnt_done != 1) begin
        n_fail++; $display("FAIL a_done(%h): got %b count %0d want 1 count 1", chars[c], done_tr[r+34], cnt_done);
      end
    end
  endtask

  task automatic test_digits();
    int r, nm;
    push(8'h35);
    capture(60);
    r = first_read(); if (r < 0) r = 0;
    exp_clear(); seg(0, 1);
    for (int i = 0; i < 4; i++) begin seg(1, 4); seg(0, 4); end
    seg(1, 4); seg(0, 12);
    nm = key_mismatches(r + 1);
    n_checks++; if (nm != 0) begin n_fail++; $display("FAIL five_key_wave: %0d cycles differ want 0", nm); end
    n_checks++; if (done_tr[r+50] !== 1'b1) begin n_fail++; $display("FAIL five_done_pos: got %b want 1", done_tr[r+50]); end
    push(8'h30);
    capture(100);
    r = first_read(); if (r < 0) r = 0;
    exp_clear(); seg(0, 1);
    for (int i = 0; i < 4; i++) begin seg(1, 12); seg(0, 4); end
    seg(1, 12); seg(0, 12);
    nm = key_mismatches(r + 1);
    n_checks++; if (nm != 0) begin n_fail++; $display("FAIL zero_key_wave: %0d cycles differ want 0", nm); end
    n_checks++; if (done_tr[r+90] !== 1'b1) begin n_fail++; $display("FAIL zero_done_pos: got %b want 1", done_tr[r+90]); end
  endtask

  task automatic test_back_to_back();
    int r, nm;
    push(8'h45); push(8'h20); push(8'h54);
    capture(90);
    r = first_read(); if (r < 0) r = 0;
    n_checks++; if (cnt_rd != 3) begin n_fail++; $display("FAIL seq_read_count: got %0d want 3", cnt_rd); end
    n_checks++; if (rd_tr[r+19] !== 1'b1 || rd_tr[r+38] !== 1'b1) begin
      n_fail++; $display("FAIL seq_read_pos: got %b%b want 11", rd_tr[r+19], rd_tr[r+38]);
    end
    // E mark, E char gap + space word gap + fetch overhead, T mark, T char gap
    exp_clear(); seg(0, 1); seg(1, 4); seg(0, 34); seg(1, 12); seg(0, 12);
    nm = key_mismatches(r + 1);
    n_checks++; if (nm != 0) begin n_fail++; $display("FAIL seq_key_wave: %0d cycles differ want 0", nm); end
    n_checks++; if (cnt_done != 3) begin n_fail++; $display("FAIL seq_done_count: got %0d want 3", cnt_done); end
    n_checks++; if (done_tr[r+37] !== 1'b1 || done_tr[r+64] !== 1'b1) begin
      n_fail++; $display("FAIL seq_done_pos: got %b%b want 11", done_tr[r+37], done_tr[r+64]);
    end
  endtask

  task automatic test_bad_char();
    int r, nm;
    push(8'h23); push(8'h45);
    capture(40);
    r = first_read(); if (r < 0) r = 0;
    n_checks++; if (bad_tr[r+2] !== 1'b1 || cnt_bad != 1) begin
      n_fail++; $display("FAIL bad_pulse: got %b count %0d want 1 count 1", bad_tr[r+2], cnt_bad);
    end
    n_checks++; if (rd_tr[r+3] !== 1'b1 || cnt_rd != 2) begin
      n_fail++; $display("FAIL bad_next_fetch: got %b count %0d want 1 count 2", rd_tr[r+3], cnt_rd);
    end
    exp_clear(); seg(0, 5); seg(1, 4); seg(0, 12);
    nm = key_mismatches(r);
    n_checks++; if (nm != 0) begin n_fail++; $display("FAIL bad_key_wave: %0d cycles differ want 0", nm); end
    n_checks++; if (done_tr[r+21] !== 1'b1 || cnt_done != 1) begin
      n_fail++; $display("FAIL bad_done: got %b count %0d want 1 count 1", done_tr[r+21], cnt_done);
    end
  endtask

  task automatic test_enable_low();
    bit ok;
    push(8'h54); push(8'h45);
    wait_read(20, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL en_read_timeout: got none want one"); end
    enable_i = 1'b0;
    capture(40);
    n_checks++; if (cnt_key != 12 || key_tr[1] !== 1'b1) begin
      n_fail++; $display("FAIL en_t_mark: got %0d high first %b want 12 first 1", cnt_key, key_tr[1]);
    end
    n_checks++; if (done_tr[25] !== 1'b1 || cnt_done != 1) begin
      n_fail++; $display("FAIL en_t_done: got %b count %0d want 1 count 1", done_tr[25], cnt_done);
    end
    n_checks++; if (cnt_rd != 0) begin n_fail++; $display("FAIL en_no_read: got %0d want 0", cnt_rd); end
    n_checks++; if (busy_tr[39] !== 1'b0) begin n_fail++; $display("FAIL en_idle: got busy %b want 0", busy_tr[39]); end
  endtask

  task automatic test_reset_mid_mark();
    bit ok;
    int r, nm;
    push(8'h49);
    enable_i = 1'b1;
    wait_read(20, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_read_timeout: got none want one"); end
    @(negedge clk_i);
    @(negedge clk_i);
    n_checks++; if (key_o !== 1'b1) begin n_fail++; $display("FAIL rst_pre_mark: got %b want 1", key_o); end
    #2 reset_i = 1'b1;
    #1;
    n_checks++; if (key_o !== 1'b0)  begin n_fail++; $display("FAIL rst_key_drop: got %b want 0", key_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy_drop: got %b want 0", busy_o); end
    @(negedge clk_i);
    reset_i = 1'b0;
    capture(40);
    r = first_read();
    n_checks++; if (r < 0 || cnt_rd != 1) begin n_fail++; $display("FAIL restart_read: got first %0d count %0d want one", r, cnt_rd); r = 0; end
    exp_clear(); seg(0, 1); seg(1, 4); seg(0, 4); seg(1, 4); seg(0, 12);
    nm = key_mismatches(r + 1);
    n_checks++; if (nm != 0) begin n_fail++; $display("FAIL restart_i_wave: %0d cycles differ want 0", nm); end
    n_checks++; if (done_tr[r+26] !== 1'b1) begin n_fail++; $display("FAIL restart_done: got %b want 1", done_tr[r+26]); end
  endtask

  initial begin
    test_reset();
    test_letter_e();
    test_letter_a();
    test_digits();
    test_back_to_back();
    test_bad_char();
    test_enable_low();
    test_reset_mid_mark();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/morse_scheduler.md
Name: morse_scheduler

Overview:
- Read-side controller for the character FIFO.
- Pops one ASCII byte at a time whenever the FIFO is non-empty and enabled, and looks up its Morse code.
- Sequences dot/dash/gap timing on a single keyed output (LED/buzzer).
- The only agent that issues FIFO reads; the UART RX side owns writes.

Parameters:
- UNIT_TICKS, 12_000_000, clk_i cycles per Morse time unit (min 2).
- WORD_BITS, 8, FIFO word width; only the low 7 bits are decoded.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset, asynchronous, active-high
- enable_i  in  1  allow fetching new characters
- fifo_empty_i  in  1  FIFO empty flag (registered in FIFO)
- fifo_rdata_i  in  WORD_BITS  FIFO head word, valid whenever not empty
- fifo_read_o  out  1  one-cycle pop strobe
- key_o  out  1  Morse output, 1 = tone on
- busy_o  out  1  high in every state except IDLE
- char_done_o  out  1  one-cycle pulse when a character (incl. gap) completes
- bad_char_o  out  1  one-cycle pulse when an unsupported byte is dropped

Behaviour:
- Reset (async):
  - State goes to IDLE.
  - All outputs go to 0 immediately: key_o, fifo_read_o, busy_o, char_done_o, bad_char_o.
  - Counters and element index clear.
- All outputs are registered.
- States: IDLE, FETCH, LOOKUP, MARK, ELEM_GAP, CHAR_GAP, WORD_GAP.
- IDLE: if enable_i && !fifo_empty_i, go to FETCH. Otherwise stay.
- FETCH (1 cycle):
  - fifo_read_o = 1.
  - Latch fifo_rdata_i into char_q.
  - Go to LOOKUP.
- LOOKUP (1 cycle): decode char_q.
  - 'A'-'Z', 'a'-'z' (case folded), '0'-'9': load len (1..5) and pattern (LSB = first element, 1 = dash); go to MARK.
  - 0x20 space: go to WORD_GAP.
  - Anything else: pulse bad_char_o, go to IDLE. No key activity.
- MARK:
  - key_o = 1 for 1 unit (dot) or 3 units (dash).
  - Then, if elements remain, go to ELEM_GAP; else go to CHAR_GAP.
- ELEM_GAP: key_o = 0 for 1 unit, advance element index, go to MARK.
- CHAR_GAP: key_o = 0 for 3 units.
- WORD_GAP: key_o = 0 for 4 units. Together with the preceding CHAR_GAP this gives the standard 7-unit word gap.
- Leaving CHAR_GAP or WORD_GAP: pulse char_done_o, go to IDLE.
- Latency:
  - fifo_read_o asserted in cycle N.
  - key_o first high in cycle N+2.
  - Each timed state lasts exactly k*UNIT_TICKS cycles.
- Timer: one down-counter loaded with k*UNIT_TICKS-1 on state entry. Width = clog2(4*UNIT_TICKS).
- FIFO interaction:
  - At most one fifo_read_o per character.
  - No read is issued while fifo_empty_i = 1.
  - The minimum 2-cycle spacing between reads covers the FIFO's registered empty-flag update.
- enable_i is sampled only in IDLE. Deasserting it mid-character finishes that character, including its gap, then holds in IDLE.
- Back-to-back characters: no extra idle units beyond the defined gaps, only the 2 FETCH/LOOKUP cycles.
- Reset mid-MARK drops key_o in the same cycle. The popped character is lost (accepted).

Decomposition:
- Shared include morse_defs.vh holds:
  - state encodings
  - unit multiples: DOT=1, DASH=3, ELEM_GAP=1, CHAR_GAP=3, WORD_GAP=4
  - ASCII constants
- Sub-module morse_lut: combinational ROM, ascii[6:0] -> {valid, len[2:0], pattern[4:0]}. Case folding happens inside it.
- The scheduler holds the FSM, timer, and element index.

Test Plan:
- UNIT_TICKS=4, FIFO preloaded with 'E' (0x45):
  - one fifo_read_o pulse
  - key_o high 4 cycles starting 2 cycles after the read
  - key_o low 12 cycles
  - char_done_o pulse, then busy_o = 0
- 'A' (0x41): key_o pattern high 4 / low 4 / high 12 / low 12, then char_done_o. 'a' (0x61) gives an identical waveform.
- '5' (0x35): five 4-cycle marks separated by 4-cycle gaps. '0' (0x30): five 12-cycle marks.
- Sequence 'E', ' ', 'T':
  - space produces 16 low cycles after E's 12-cycle gap
  - exactly 3 read pulses
  - 3 char_done_o pulses
- '#' (0x23) then 'E':
  - bad_char_o pulses once, 2 cycles after its read
  - key_o stays low
  - 'E' fetched in the next cycle
- Edge cases:
  - enable_i low during 'T': T completes, no further reads while FIFO is non-empty.
  - reset_i during MARK: key_o = 0 and busy_o = 0 immediately.
  - Restart after reset: fetches the next FIFO word.
